// File: rtl/shifter_arbiter.sv
// Two-port round-robin front end sharing one 16-bit barrel shifter, with a single
// registered, id-tagged response channel (valid/ready on every port).

module barrel_shifter #(
  parameter int W  = 16,
  parameter int SW = 4,
  parameter int OW = 2
) (
  input  logic [W-1:0]  operand,
  input  logic [SW-1:0] shamt,
  input  logic [OW-1:0] oper,
  output logic [W-1:0]  result
);

  logic [2*W-1:0] dbl_l;
  logic [2*W-1:0] dbl_r;

  // Rotations come from shifting the operand concatenated with itself.
  always_comb begin
    dbl_l = {operand, operand} << shamt;
    dbl_r = {operand, operand} >> shamt;
    if (oper[1]) result = oper[0] ? (operand >> shamt) : dbl_r[W-1:0];
    else         result = oper[0] ? (operand << shamt) : dbl_l[2*W-1:W];
  end

endmodule

module shifter_arbiter #(
  parameter int OPERAND_WIDTH  = 16,
  parameter int SHAMT_WIDTH    = 4,
  parameter int NUM_OPERATIONS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [OPERAND_WIDTH-1:0]  req0_in,
  input  logic [SHAMT_WIDTH-1:0]    req0_shamt,
  input  logic [NUM_OPERATIONS-1:0] req0_oper,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [OPERAND_WIDTH-1:0]  req1_in,
  input  logic [SHAMT_WIDTH-1:0]    req1_shamt,
  input  logic [NUM_OPERATIONS-1:0] req1_oper,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_id,
  output logic [OPERAND_WIDTH-1:0]  resp_data
);

  logic                      last_grant;
  logic                      grant_valid;
  logic                      grant_id;
  logic                      can_accept;
  logic                      transfer;
  logic [OPERAND_WIDTH-1:0]  sel_in;
  logic [SHAMT_WIDTH-1:0]    sel_shamt;
  logic [NUM_OPERATIONS-1:0] sel_oper;
  logic [OPERAND_WIDTH-1:0]  shift_out;

  // Round-robin: on a tie the requester that did not win last time goes next.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign can_accept = !resp_valid || resp_ready;
  assign transfer   = grant_valid && can_accept;
  assign req0_ready = can_accept && grant_valid && !grant_id;
  assign req1_ready = can_accept && grant_valid &&  grant_id;

  assign sel_in    = grant_id ? req1_in    : req0_in;
  assign sel_shamt = grant_id ? req1_shamt : req0_shamt;
  assign sel_oper  = grant_id ? req1_oper  : req0_oper;

  barrel_shifter #(
    .W  (OPERAND_WIDTH),
    .SW (SHAMT_WIDTH),
    .OW (NUM_OPERATIONS)
  ) u_shifter (
    .operand (sel_in),
    .shamt   (sel_shamt),
    .oper    (sel_oper),
    .result  (shift_out)
  );

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      last_grant <= 1'b1;
    end else if (transfer) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      resp_valid <= 1'b1;
      resp_id    <= grant_id;
      resp_data  <= shift_out;
      last_grant <= grant_id;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter: drivers push expected results at acceptance,
// an independent monitor pops and compares whenever a response is consumed.

module tb_shifter_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_in, req1_in;
  logic [3:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_oper, req1_oper;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] resp_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wait0    = 0;
  int wait1    = 0;
  bit rand_done;

  logic [16:0] exp_q[$];
  logic        grant_q[$];
  int          acc_cyc[$];

  logic [21:0] hold0, hold1;
  bit          stall0 = 0, stall1 = 0;

  shifter_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in    (req0_in),
    .req0_shamt (req0_shamt),
    .req0_oper  (req0_oper),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in    (req1_in),
    .req1_shamt (req1_shamt),
    .req1_oper  (req1_oper),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bit-serial reference: one single-bit step per shift position.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] s,
                                            input logic [1:0] o);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(s); i++) begin
      case (o)
        2'b00:   r = {r[14:0], r[15]};
        2'b01:   r = {r[14:0], 1'b0};
        2'b10:   r = {r[0], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  // Present one request on port p and hold it until accepted; returns at posedge+1.
  task automatic send(input int p, input logic [15:0] d, input logic [3:0] s,
                      input logic [1:0] o, input logic [15:0] expd);
    int  n    = 0;
    bit  done = 0;
    if (p == 0) begin req0_valid = 1; req0_in = d; req0_shamt = s; req0_oper = o; end
    else        begin req1_valid = 1; req1_in = d; req1_shamt = s; req1_oper = o; end
    while (!done) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) begin
        exp_q.push_back({p[0], expd});
        grant_q.push_back(p[0]);
        acc_cyc.push_back(cyc);
        done = 1;
      end else if (++n > 200) begin
        check("send_timeout", 32'(n), 32'd0);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic rand_drive(input int p, input int n);
    logic [15:0] d;
    logic [3:0]  s;
    logic [1:0]  o;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = 16'($urandom);
      s = 4'($urandom_range(0, 15));
      o = 2'($urandom_range(0, 3));
      send(p, d, s, o, ref_shift(d, s, o));
    end
  endtask

  // Monitor: scoreboard pop, dual-ready and fairness checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) check("unexpected_resp", {15'd0, resp_id, resp_data}, 32'd0);
        else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("resp_id", 32'(resp_id), 32'(e[16]));
          check("resp_data", 32'(resp_data), 32'(e[15:0]));
        end
      end
      if (req0_valid && req1_valid) check("dual_ready", 32'(req0_ready && req1_ready), 32'd0);
      if (req0_valid && !req0_ready && req1_valid && req1_ready) begin
        check("fair_req0", 32'(wait0), 32'd0);
        wait0 <= wait0 + 1;
      end else if (!req0_valid || req0_ready) wait0 <= 0;
      if (req1_valid && !req1_ready && req0_valid && req0_ready) begin
        check("fair_req1", 32'(wait1), 32'd0);
        wait1 <= wait1 + 1;
      end else if (!req1_valid || req1_ready) wait1 <= 0;
    end
  end

  // Requester-side protocol: payload must stay stable while stalled.
  always @(negedge clk) begin
    if (stall0 && req0_valid)
      assert ({req0_in, req0_shamt, req0_oper} == hold0) else $error("req0 payload changed while stalled");
    if (stall1 && req1_valid)
      assert ({req1_in, req1_shamt, req1_oper} == hold1) else $error("req1 payload changed while stalled");
    stall0 <= req0_valid && !req0_ready;
    stall1 <= req1_valid && !req1_ready;
    hold0  <= {req0_in, req0_shamt, req0_oper};
    hold1  <= {req1_in, req1_shamt, req1_oper};
  end

  initial begin
    int n;
    logic [1:0] ex_grants [4];
    ex_grants = '{2'd0, 2'd1, 2'd0, 2'd1};
    rst_n = 0; resp_ready = 1;
    req0_valid = 0; req0_in = '0; req0_shamt = '0; req0_oper = '0;
    req1_valid = 0; req1_in = '0; req1_shamt = '0; req1_oper = '0;
    #3;
    check("reset_valid", 32'(resp_valid), 32'd0);
    check("reset_id", 32'(resp_id), 32'd0);
    check("reset_data", 32'(resp_data), 32'd0);
    #4 rst_n = 1;
    @(posedge clk); #1;

    // Single req0 rotl, one-cycle latency.
    send(0, 16'h8001, 4'd1, 2'b00, 16'h0003);
    @(negedge clk);
    check("lat_valid", 32'(resp_valid), 32'd1);
    check("lat_id", 32'(resp_id), 32'd0);
    check("lat_data", 32'(resp_data), 32'h0003);

    // Reset while a result is held: cleared asynchronously and discarded.
    @(posedge clk); #1;
    resp_ready = 0;
    send(1, 16'h0001, 4'd1, 2'b10, 16'h8000);
    @(negedge clk);
    check("held_valid", 32'(resp_valid), 32'd1);
    #1 rst_n = 0;
    #1;
    check("async_rst_valid", 32'(resp_valid), 32'd0);
    check("async_rst_data", 32'(resp_data), 32'd0);
    check("async_rst_id", 32'(resp_id), 32'd0);
    exp_q.delete();
    #1 rst_n = 1;
    resp_ready = 1;
    @(posedge clk); #1;

    // Both valid every cycle: tie goes to req0 first, then strict alternation.
    grant_q.delete(); acc_cyc.delete();
    fork
      begin
        send(0, 16'h00F0, 4'd4, 2'b01, 16'h0F00);
        send(0, 16'h00F0, 4'd4, 2'b01, 16'h0F00);
      end
      begin
        send(1, 16'h8000, 4'd15, 2'b11, 16'h0001);
        send(1, 16'h8000, 4'd15, 2'b11, 16'h0001);
      end
    join
    check("rr_count", 32'(grant_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check("rr_grant", 32'(grant_q[i]), 32'(ex_grants[i]));
    if (acc_cyc.size() == 4) check("rr_no_bubble", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);

    // Backpressure: result held three cycles, both readies low, then same-cycle accept.
    @(posedge clk); #1;
    @(posedge clk); #1;
    resp_ready = 0;
    send(1, 16'h0001, 4'd1, 2'b10, 16'h8000);
    req0_valid = 1; req0_in = 16'h0001; req0_shamt = 4'd1; req0_oper = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_id", 32'(resp_id), 32'd1);
      check("bp_data", 32'(resp_data), 32'h8000);
      check("bp_ready0", 32'(req0_ready), 32'd0);
      check("bp_ready1", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1;
    @(negedge clk);
    check("bp_release_accept", 32'(req0_ready), 32'd1);
    exp_q.push_back({1'b0, 16'h0002});
    @(posedge clk); #1;
    req0_valid = 0;

    // Zero shift amount leaves the operand unchanged for every op.
    send(0, 16'hA5C3, 4'd0, 2'b00, 16'hA5C3);
    send(1, 16'hA5C3, 4'd0, 2'b01, 16'hA5C3);
    send(0, 16'hA5C3, 4'd0, 2'b10, 16'hA5C3);
    send(1, 16'hA5C3, 4'd0, 2'b11, 16'hA5C3);

    // Random traffic and random consumer backpressure against the reference model.
    rand_done = 0;
    fork
      begin
        fork
          rand_drive(0, 500);
          rand_drive(1, 500);
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          resp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    resp_ready = 1;

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
